// File: rtl/imem_loader.sv
// imem_loader: boots the mips16_sc instruction memory from a byte stream.
// A 2-byte word count (MSB first) is followed by 4*N instruction bytes,
// each word MSB first. Words are written sequentially from address 0, and
// the core is held in stall until the whole program is in place.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_count;
    logic [31:0]           r_word;
    logic [1:0]            r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH:0]   r_words_loaded;

    logic                  w_accept;
    logic                  w_start_ok;
    logic [15:0]           w_hdr_count;
    logic                  w_last;

    // A byte moves only when both sides agree.
    assign w_accept    = in_valid && in_ready;
    // start is honoured only from the resting states.
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERROR));
    // Full count as it will be once the low header byte is captured.
    assign w_hdr_count = {r_count[15:8], in_data};
    // The word being written is the last one. Comparing against the
    // (ADDR_WIDTH+1)-bit counter keeps N == DEPTH exact, where the
    // ADDR_WIDTH-bit index alone would alias.
    assign w_last      = (32'(r_words_loaded) + 32'd1) == 32'(r_count);

    assign imem_addr    = r_index;
    assign imem_wdata   = r_word;
    assign words_loaded = r_words_loaded;

    // State register; reset also kills any pending write instantly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/status outputs, all decoded from the state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        imem_we     = 1'b0;
        cpu_hold    = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) w_state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    if (w_hdr_count == 16'd0)
                        w_state_nxt = S_DONE;
                    else if (32'(w_hdr_count) > DEPTH)
                        w_state_nxt = S_ERROR;
                    else
                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                imem_we     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done     = 1'b1;
                // Re-hold the core in the very cycle a reload is requested.
                cpu_hold = start;
                if (start) w_state_nxt = S_HDR_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) w_state_nxt = S_HDR_HI;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: header capture, word assembly, write index and load count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= '0;
            r_word         <= '0;
            r_byte_cnt     <= '0;
            r_index        <= '0;
            r_words_loaded <= '0;
        end else begin
            if (w_start_ok) begin
                r_byte_cnt     <= '0;
                r_index        <= '0;
                r_words_loaded <= '0;
            end
            case (r_state)
                S_HDR_HI: begin
                    if (w_accept) r_count[15:8] <= in_data;
                end
                S_HDR_LO: begin
                    if (w_accept) r_count[7:0] <= in_data;
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= {r_word[23:0], in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    // Index wraps to 0 after a full-depth load; state is
                    // DONE by then, so it is never used for a write.
                    r_index        <= r_index + ADDR_WIDTH'(1);
                    r_words_loaded <= r_words_loaded + (ADDR_WIDTH + 1)'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the mips16_sc single-cycle core. It receives a program as a byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes those words sequentially into the core's instruction register array from address 0 and holds the core stalled until the full program is in place. This is the hardware write-side counterpart of the bench-side `$readmemb` preload. It lets a board or a system-level bench boot the CPU without simulator file I/O.

## Interface
- `ADDR_WIDTH`, default 8: instruction memory address width. Depth = 2^ADDR_WIDTH words.
- `clock` input, 1 bit: system clock, rising-edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: single-cycle load request. Ignored unless the state is IDLE, DONE or ERROR.
- `in_data` input, 8 bits: stream byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `imem_we` output, 1 bit: instruction memory write enable, one-cycle pulse.
- `imem_addr` output, ADDR_WIDTH bits: write address.
- `imem_wdata` output, 32 bits: instruction word.
- `cpu_hold` output, 1 bit: core stall; 1 = core must not fetch or execute.
- `busy` output, 1 bit: a load is in progress.
- `done` output, 1 bit: the program loaded successfully.
- `error` output, 1 bit: header word count exceeds depth.
- `words_loaded` output, ADDR_WIDTH+1 bits: count of words written in the current load.

## Operation
- Stream format:
  - 2-byte header carrying the word count N, MSB byte first.
  - Then 4·N instruction bytes, each word MSB first (byte 0 → bits 31:24).
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
- IDLE: `cpu_hold`=1. `start` → HDR_HI.
- HDR_HI: `in_ready`=1. On accept, capture count[15:8] → HDR_LO.
- HDR_LO: `in_ready`=1. On accept, capture count[7:0], then:
  - N==0 → DONE.
  - N > 2^ADDR_WIDTH → ERROR.
  - otherwise → DATA.
- DATA: `in_ready`=1. Each accepted byte shifts into the word register and increments a 2-bit byte counter. On the 4th byte → WRITE.
- WRITE: `in_ready`=0 and `imem_we`=1 for exactly one cycle. `imem_addr` = word index and `imem_wdata` = assembled word. The word index and `words_loaded` increment at the end of the cycle. Next state:
  - index == N−1 → DONE.
  - otherwise → DATA.
- DONE: `done`=1, `cpu_hold`=0, `busy`=0. Holds until `start`.
- ERROR: `error`=1, `cpu_hold`=1, `in_ready`=0. Holds until `start`.
- `start` from DONE or ERROR:
  - clears `done`, `error`, `words_loaded`, the word index and the byte counter;
  - asserts `cpu_hold` the same cycle (combinational from state/start);
  - moves to HDR_HI.
- `start` in HDR_HI, HDR_LO, DATA or WRITE is ignored.
- A byte is transferred only on `in_valid && in_ready`. With `in_valid`=0 the state and counters hold indefinitely; there is no timeout.
- `busy`=1 in HDR_HI, HDR_LO, DATA and WRITE.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_hold`=1, `busy`=0, `done`=0, `error`=0, `words_loaded`=0.
- `imem_we` rises on the clock edge after the 4th byte of a word is accepted. This is 1 cycle of latency, with the memory written at the following edge.
- Minimum throughput with continuous `in_valid`: 5 cycles per word (4 accept + 1 WRITE).
- `done` rises the cycle after the last WRITE cycle. `cpu_hold` falls in that same cycle.
- Full load of N words with no stalls: 2 + 5N cycles from the first header accept to `done`.
- N == 2^ADDR_WIDTH is legal. The index wraps to 0 internally after the last write, but the state is DONE, so no further write occurs. `words_loaded` reads 2^ADDR_WIDTH.
- Reset asserted mid-load:
  - all outputs return to reset values immediately (asynchronous);
  - the pending `imem_we` is killed the same instant;
  - memory words already written are left intact;
  - the core stays held.
- The bytes following ERROR are not consumed. The source must be flushed externally before the next `start`.

## Test plan
- Reset then idle: check `cpu_hold`=1, `in_ready`=0, `imem_we`=0, `done`=0. Assert `reset_n` low with `start` pulsing and confirm nothing changes.
- Normal load:
  - stimulus: `start`, then bytes 00 02 | 20 01 00 05 | 00 21 08 20, with `in_valid` held high;
  - writes: addr 0 ← 0x20010005 and addr 1 ← 0x00210820, each as a single `imem_we` pulse;
  - completion: `done`=1 and `cpu_hold`=0 at cycle 12 after the first accept, with `words_loaded`=2.
- Backpressure and gaps: drop `in_valid` randomly during the same stream. The same two words must be written, with no duplicate or missing `imem_we`.
- N=0: bytes 00 00 → DONE directly, no `imem_we`, `cpu_hold`=0.
- Overflow with ADDR_WIDTH=4: header 00 11 (17) → `error`=1, `in_ready`=0, `cpu_hold`=1. A following `start` and header 00 10 loads 16 words, and the last write lands at addr 15.
- Reset mid-word: assert `reset_n` low after 2 bytes of word 1. Check no write and `cpu_hold`=1. After release and `start`, a fresh 1-word load writes addr 0 correctly.
